// File: rtl/cordic_rr_scheduler.sv
// Round-robin front end for a shared, fixed-latency pipelined CORDIC.
// Grants at most one requester per cycle. It registers the winner's operands
// into the pipe and carries each issue's owner tag down a delay line. The
// delay line is aligned to the pipe latency, so results can be routed back to
// the requester that issued them.
module cordic_rr_scheduler #(
  parameter int NREQ      = 4,
  parameter int DW        = 16,
  parameter int LATENCY   = 16,
  parameter int MAX_OUTST = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_x,
  input  logic [NREQ*DW-1:0]   req_y,
  input  logic [NREQ*DW-1:0]   req_z,
  output logic                 pipe_valid,
  output logic [DW-1:0]        pipe_x,
  output logic [DW-1:0]        pipe_y,
  output logic [DW-1:0]        pipe_z,
  input  logic                 res_valid,
  input  logic [DW-1:0]        res_x,
  input  logic [DW-1:0]        res_y,
  input  logic [DW-1:0]        res_z,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_x,
  output logic [DW-1:0]        rsp_y,
  output logic [DW-1:0]        rsp_z,
  output logic                 busy,
  output logic                 err
);

  localparam int TW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_OUTST + 1);

  logic [TW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q [NREQ];
  logic [CW-1:0]   cnt_d [NREQ];
  logic            pipe_valid_q, pipe_valid_d;
  logic [DW-1:0]   pipe_x_q, pipe_x_d;
  logic [DW-1:0]   pipe_y_q, pipe_y_d;
  logic [DW-1:0]   pipe_z_q, pipe_z_d;
  logic [TW-1:0]   pipe_tag_q, pipe_tag_d;
  logic [LATENCY-1:0] dl_v_q, dl_v_d;
  logic [TW-1:0]   dl_tag_q [LATENCY];
  logic [TW-1:0]   dl_tag_d [LATENCY];
  logic            err_q, err_d;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] elig_rot;
  logic            grant_found;
  logic [TW:0]     grant_sum;
  logic [TW-1:0]   grant_idx;
  logic            accept;
  logic [DW-1:0]   sel_x, sel_y, sel_z;
  logic            ret_v;
  logic [TW-1:0]   ret_tag;
  logic [NREQ-1:0] inc, dec;

  // Eligibility: requesting and still below the per-requester in-flight cap.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++)
      eligible[i] = req_valid[i] && (cnt_q[i] < CW'(MAX_OUTST));
  end

  // Rotate eligibility so bit 0 is the pointer slot, take the first hit, map back.
  always_comb begin
    elig_rot    = NREQ'({eligible, eligible} >> ptr_q);
    grant_found = 1'b0;
    grant_sum   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (elig_rot[k]) begin
        grant_found = 1'b1;
        grant_sum   = {1'b0, ptr_q} + (TW+1)'(k);
      end
    end
    if (grant_sum >= (TW+1)'(NREQ))
      grant_sum = grant_sum - (TW+1)'(NREQ);
    grant_idx = grant_sum[TW-1:0];
  end

  assign accept = grant_found & ~reset;

  // One-hot ready to the winner; nothing is granted while reset is held.
  always_comb begin
    req_ready = '0;
    if (accept)
      req_ready[grant_idx] = 1'b1;
  end

  // Operand select for the winning requester.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_z = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == TW'(i)) begin
        sel_x = req_x[i*DW +: DW];
        sel_y = req_y[i*DW +: DW];
        sel_z = req_z[i*DW +: DW];
      end
    end
  end

  // Pipe input register; operands hold their last value when nothing issues.
  always_comb begin
    pipe_valid_d = accept;
    pipe_x_d     = pipe_x_q;
    pipe_y_d     = pipe_y_q;
    pipe_z_d     = pipe_z_q;
    pipe_tag_d   = pipe_tag_q;
    ptr_d        = ptr_q;
    if (accept) begin
      pipe_x_d   = sel_x;
      pipe_y_d   = sel_y;
      pipe_z_d   = sel_z;
      pipe_tag_d = grant_idx;
      ptr_d      = (grant_idx == TW'(NREQ - 1)) ? '0 : grant_idx + TW'(1);
    end
  end

  // The tag follows pipe_valid through LATENCY stages, mirroring the CORDIC stages.
  always_comb begin
    dl_v_d      = {dl_v_q[LATENCY-2:0], pipe_valid_q};
    dl_tag_d[0] = pipe_tag_q;
    for (int k = 1; k < LATENCY; k++)
      dl_tag_d[k] = dl_tag_q[k-1];
  end

  assign ret_v   = dl_v_q[LATENCY-1];
  assign ret_tag = dl_tag_q[LATENCY-1];

  // Route a matched result to its owner; the data bus reads zero when no strobe.
  always_comb begin
    rsp_valid = '0;
    rsp_x     = '0;
    rsp_y     = '0;
    rsp_z     = '0;
    if (ret_v && res_valid) begin
      rsp_valid[ret_tag] = 1'b1;
      rsp_x = res_x;
      rsp_y = res_y;
      rsp_z = res_z;
    end
  end

  // Outstanding counters. A dropped result still retires its slot.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < NREQ; i++) begin
      inc[i]   = accept && (grant_idx == TW'(i));
      dec[i]   = ret_v && (ret_tag == TW'(i));
      cnt_d[i] = cnt_q[i];
      if (inc[i] && !dec[i])
        cnt_d[i] = cnt_q[i] + CW'(1);
      else if (!inc[i] && dec[i])
        cnt_d[i] = cnt_q[i] - CW'(1);
    end
  end

  // Sticky flag for any disagreement between expected and actual pipe output.
  always_comb begin
    err_d = err_q | (ret_v ^ res_valid);
  end

  // Busy while any requester has work in the pipe.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (cnt_q[i] != '0)
        busy = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q        <= '0;
      pipe_valid_q <= 1'b0;
      pipe_x_q     <= '0;
      pipe_y_q     <= '0;
      pipe_z_q     <= '0;
      pipe_tag_q   <= '0;
      dl_v_q       <= '0;
      err_q        <= 1'b0;
      for (int k = 0; k < LATENCY; k++)
        dl_tag_q[k] <= '0;
      for (int i = 0; i < NREQ; i++)
        cnt_q[i] <= '0;
    end else begin
      ptr_q        <= ptr_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_x_q     <= pipe_x_d;
      pipe_y_q     <= pipe_y_d;
      pipe_z_q     <= pipe_z_d;
      pipe_tag_q   <= pipe_tag_d;
      dl_v_q       <= dl_v_d;
      err_q        <= err_d;
      for (int k = 0; k < LATENCY; k++)
        dl_tag_q[k] <= dl_tag_d[k];
      for (int i = 0; i < NREQ; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  assign pipe_valid = pipe_valid_q;
  assign pipe_x     = pipe_x_q;
  assign pipe_y     = pipe_y_q;
  assign pipe_z     = pipe_z_q;
  assign err        = err_q;

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Bench for cordic_rr_scheduler. A behavioural CORDIC stand-in delays the pipe
// outputs by LAT cycles and applies a fixed transform. The issue model keeps
// one record per in-flight operation and predicts grants, pipe contents and
// busy. The monitor pops a scoreboard of expected responses.
module tb_cordic_rr_scheduler;
  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int LAT  = 16;
  localparam int MAXO = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid, req_ready, rsp_valid;
  logic [NREQ*DW-1:0] req_x, req_y, req_z;
  logic              pipe_valid, res_valid, busy, err;
  logic [DW-1:0]     pipe_x, pipe_y, pipe_z, res_x, res_y, res_z, rsp_x, rsp_y, rsp_z;
  logic              drop, inject;

  cordic_rr_scheduler #(.NREQ(NREQ), .DW(DW), .LATENCY(LAT), .MAX_OUTST(MAXO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .pipe_valid(pipe_valid), .pipe_x(pipe_x), .pipe_y(pipe_y), .pipe_z(pipe_z),
    .res_valid(res_valid), .res_x(res_x), .res_y(res_y), .res_z(res_z),
    .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3*DW-1:0] cordic_f(input logic [3*DW-1:0] ops);
    return {ops[3*DW-1:2*DW] ^ 16'hA5A5, ops[2*DW-1:DW] + 16'h0001, ~ops[DW-1:0]};
  endfunction

  // Stand-in CORDIC: LAT register stages, cleared by the shared reset.
  logic [LAT-1:0]    fp_v;
  logic [3*DW-1:0]   fp_d [LAT];
  always @(posedge clk) begin
    if (reset) begin
      fp_v <= '0;
    end else begin
      fp_v    <= {fp_v[LAT-2:0], pipe_valid};
      fp_d[0] <= {pipe_x, pipe_y, pipe_z};
      for (int k = 1; k < LAT; k++) fp_d[k] <= fp_d[k-1];
    end
  end
  assign res_valid = (fp_v[LAT-1] & ~drop) | inject;
  assign {res_x, res_y, res_z} = fp_v[LAT-1] ? cordic_f(fp_d[LAT-1]) : 48'h0BAD_DEAD_BEEF;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  typedef struct { int tag; int ret; } rec_t;
  typedef struct { int tag; int ret; logic [3*DW-1:0] data; } exp_t;
  rec_t recs[$];
  exp_t sbq[$];
  int   ptr_m = 0;
  logic prev_acc = 1'b0;
  logic [3*DW-1:0] last_ops = '0;
  logic err_m = 1'b0;

  // Issue model: grant prediction from in-flight records, pipe/busy checks, scoreboard push.
  always @(negedge clk) begin
    int cnt [NREQ];
    rec_t keep[$];
    logic [NREQ-1:0] exp_ready;
    logic [3*DW-1:0] ops;
    int win;
    if (reset) begin
      check("ready_in_reset", 64'(req_ready), 64'(0));
      recs.delete();
      ptr_m    = 0;
      prev_acc = 1'b0;
      last_ops = '0;
    end else begin
      check("pipe_valid", 64'(pipe_valid), 64'(prev_acc));
      check("pipe_ops", 64'({pipe_x, pipe_y, pipe_z}), 64'(last_ops));
      keep = {};
      foreach (recs[j]) if (recs[j].ret >= cyc) keep.push_back(recs[j]);
      recs = keep;
      for (int i = 0; i < NREQ; i++) cnt[i] = 0;
      foreach (recs[j]) cnt[recs[j].tag]++;
      check("busy", 64'(busy), 64'(recs.size() != 0));
      win = -1;
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (ptr_m + k) % NREQ;
        if (win < 0 && req_valid[i] && cnt[i] < MAXO) win = i;
      end
      exp_ready = '0;
      if (win >= 0) exp_ready[win] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      prev_acc = 1'b0;
      if (win >= 0) begin
        ops = {req_x[win*DW +: DW], req_y[win*DW +: DW], req_z[win*DW +: DW]};
        recs.push_back('{tag: win, ret: cyc + 1 + LAT});
        sbq.push_back('{tag: win, ret: cyc + 1 + LAT, data: cordic_f(ops)});
        last_ops = ops;
        prev_acc = 1'b1;
        ptr_m    = (win + 1) % NREQ;
      end
    end
  end

  // Response monitor: pops the scoreboard when an entry is due and tracks the sticky error.
  always @(negedge clk) begin
    logic due;
    logic [NREQ-1:0] exp_rv;
    if (reset) begin
      sbq.delete();
      err_m = 1'b0;
    end else begin
      check("err", 64'(err), 64'(err_m));
      due = (sbq.size() > 0) && (sbq[0].ret == cyc);
      if (due && !drop) begin
        exp_rv = '0;
        exp_rv[sbq[0].tag] = 1'b1;
        check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        check("rsp_data", 64'({rsp_x, rsp_y, rsp_z}), 64'(sbq[0].data));
        void'(sbq.pop_front());
      end else begin
        check("rsp_idle", 64'(rsp_valid), 64'(0));
        check("rsp_data_idle", 64'({rsp_x, rsp_y, rsp_z}), 64'(0));
        if (due) void'(sbq.pop_front());
      end
      if ((due && drop) || (!due && inject)) err_m = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*DW +: DW] = DW'($urandom);
      req_y[i*DW +: DW] = DW'($urandom);
      req_z[i*DW +: DW] = DW'($urandom);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_x = '0; req_y = '0; req_z = '0;
    drop = 1'b0; inject = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Single request from requester 0.
    req_valid = 4'b0001;
    req_x[0 +: DW] = 16'h4000; req_y[0 +: DW] = 16'h0000; req_z[0 +: DW] = 16'h1000;
    step();
    req_valid = '0;
    repeat (LAT + 6) step();

    // All four requesters held valid for 8 cycles.
    req_valid = 4'hF;
    repeat (8) begin rand_ops(); step(); end
    req_valid = '0;
    repeat (LAT + 6) step();

    // Requester 2 alone, long enough to hit the in-flight cap and recover.
    req_valid = 4'b0100;
    repeat (45) begin rand_ops(); step(); end
    req_valid = '0;
    repeat (LAT + 6) step();

    // Random traffic, clean pipe.
    repeat (400) begin
      rand_ops();
      req_valid = NREQ'($urandom_range(0, 15));
      step();
    end

    // Random traffic with dropped and stray results.
    repeat (200) begin
      rand_ops();
      req_valid = NREQ'($urandom_range(0, 15));
      drop   = ($urandom_range(0, 9) == 0);
      inject = !drop && ($urandom_range(0, 29) == 0);
      step();
    end
    drop = 1'b0; inject = 1'b0;

    // Reset with operations in flight.
    req_valid = 4'hF;
    repeat (5) begin rand_ops(); step(); end
    req_valid = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    repeat (100) begin
      rand_ops();
      req_valid = NREQ'($urandom_range(0, 15));
      step();
    end
    req_valid = '0;
    repeat (LAT + 6) step();
    check("scoreboard_drained", 64'(sbq.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
